// File: rtl/alu_seq.sv
// Registered, width-parametrised CPU ALU with a start/busy/done handshake.
// Single-cycle ops finish in one clock; multi-bit shifts and shift-add multiply iterate in RUN.
module alu_seq #(
    parameter int WIDTH = 8,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [3:0]       alu_op_in,
    input  logic [3:0]       status_in,
    output logic [WIDTH-1:0] result_out,
    output logic [3:0]       status_out,
    output logic             busy_out,
    output logic             done_out
);

    localparam int CW = SHW + 1;
    localparam logic [CW-1:0] MUL_CNT = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    localparam logic [3:0] OP_SLR = 4'h0;
    localparam logic [3:0] OP_SLL = 4'h1;
    localparam logic [3:0] OP_SRN = 4'h2;
    localparam logic [3:0] OP_SLN = 4'h3;
    localparam logic [3:0] OP_INC = 4'h4;
    localparam logic [3:0] OP_DEC = 4'h5;
    localparam logic [3:0] OP_ADD = 4'h6;
    localparam logic [3:0] OP_ADC = 4'h7;
    localparam logic [3:0] OP_NOT = 4'h8;
    localparam logic [3:0] OP_AND = 4'h9;
    localparam logic [3:0] OP_OR  = 4'hA;
    localparam logic [3:0] OP_MOV = 4'hB;
    localparam logic [3:0] OP_XOR = 4'hC;
    localparam logic [3:0] OP_MUL = 4'hD;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_t;

    state_t           r_state;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mq;
    logic [3:0]       r_st;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_result;
    logic [3:0]       r_status;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_res;
    logic [3:0]       w_st;
    logic [3:0]       w_st_out;
    logic             w_zn;
    logic             w_multi;

    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH-1:0] w_shift;
    logic             w_shift_c;
    logic [WIDTH-1:0] w_fin_res;
    logic             w_fin_c;
    logic             w_last;
    logic [3:0]       w_fin_st;

    // Single-cycle datapath: result and flags straight from the live operands.
    always_comb begin
        w_sum   = {(WIDTH+1){1'b0}};
        w_res   = a_in;
        w_st    = status_in;
        w_zn    = 1'b1;
        w_multi = 1'b0;
        case (alu_op_in)
            OP_SLR: begin
                w_res   = {1'b0, a_in[WIDTH-1:1]};
                w_st[0] = a_in[0];
            end
            OP_SLL: begin
                w_res   = {a_in[WIDTH-2:0], 1'b0};
                w_st[0] = a_in[WIDTH-1];
            end
            OP_INC: begin
                w_sum   = {1'b0, a_in} + {{WIDTH{1'b0}}, 1'b1};
                w_res   = w_sum[WIDTH-1:0];
                w_st[0] = w_sum[WIDTH];
                w_st[3] = ~a_in[WIDTH-1] & w_sum[WIDTH-1];
            end
            OP_DEC: begin
                // Borrow out of the WIDTH+1 subtraction lands in the MSB.
                w_sum   = {1'b0, a_in} - {{WIDTH{1'b0}}, 1'b1};
                w_res   = w_sum[WIDTH-1:0];
                w_st[0] = w_sum[WIDTH];
                w_st[3] = a_in[WIDTH-1] & ~w_sum[WIDTH-1];
            end
            OP_ADD, OP_ADC: begin
                w_sum   = {1'b0, a_in} + {1'b0, b_in}
                        + {{WIDTH{1'b0}}, (alu_op_in == OP_ADC) & status_in[0]};
                w_res   = w_sum[WIDTH-1:0];
                w_st[0] = w_sum[WIDTH];
                w_st[3] = (a_in[WIDTH-1] ~^ b_in[WIDTH-1]) & (w_sum[WIDTH-1] ^ a_in[WIDTH-1]);
            end
            OP_NOT: w_res = ~a_in;
            OP_AND: w_res = a_in & b_in;
            OP_OR:  w_res = a_in | b_in;
            OP_MOV: w_res = b_in;
            OP_XOR: w_res = a_in ^ b_in;
            OP_SRN, OP_SLN, OP_MUL: w_multi = 1'b1;
            default: w_zn = 1'b0;
        endcase
    end

    assign w_st_out = w_zn ? {w_st[3], w_res[WIDTH-1], (w_res == {WIDTH{1'b0}}), w_st[0]} : w_st;

    // Per-iteration datapath for the multi-cycle ops and their final result/flags.
    always_comb begin
        w_mul_sum = {1'b0, r_acc} + (r_mq[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
        case (r_op)
            OP_SRN: begin
                w_shift   = {1'b0, r_acc[WIDTH-1:1]};
                w_shift_c = r_acc[0];
            end
            default: begin
                w_shift   = {r_acc[WIDTH-2:0], 1'b0};
                w_shift_c = r_acc[WIDTH-1];
            end
        endcase
        if (r_op == OP_MUL) begin
            w_last    = (r_cnt == CNT_ONE);
            w_fin_res = {w_mul_sum[0], r_mq[WIDTH-1:1]};
            w_fin_c   = |w_mul_sum[WIDTH:1];
        end else if (r_cnt == CNT_ZERO) begin
            // Zero-length shift still spends one RUN cycle and keeps C.
            w_last    = 1'b1;
            w_fin_res = r_acc;
            w_fin_c   = r_st[0];
        end else begin
            w_last    = (r_cnt == CNT_ONE);
            w_fin_res = w_shift;
            w_fin_c   = w_shift_c;
        end
    end

    assign w_fin_st = {r_st[3], w_fin_res[WIDTH-1], (w_fin_res == {WIDTH{1'b0}}), w_fin_c};

    // Control FSM with all result/status/handshake outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_op     <= 4'h0;
            r_a      <= {WIDTH{1'b0}};
            r_acc    <= {WIDTH{1'b0}};
            r_mq     <= {WIDTH{1'b0}};
            r_st     <= 4'h0;
            r_cnt    <= CNT_ZERO;
            r_result <= {WIDTH{1'b0}};
            r_status <= 4'h0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start_in && w_multi) begin
                        r_op    <= alu_op_in;
                        r_a     <= a_in;
                        r_st    <= status_in;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                        if (alu_op_in == OP_MUL) begin
                            r_acc <= {WIDTH{1'b0}};
                            r_mq  <= b_in;
                            r_cnt <= MUL_CNT;
                        end else begin
                            r_acc <= a_in;
                            r_mq  <= {WIDTH{1'b0}};
                            r_cnt <= {1'b0, b_in[SHW-1:0]};
                        end
                    end else if (start_in) begin
                        r_result <= w_res;
                        r_status <= w_st_out;
                        r_done   <= 1'b1;
                    end
                end
                RUN: begin
                    if (r_op == OP_MUL) begin
                        r_acc <= w_mul_sum[WIDTH:1];
                        r_mq  <= {w_mul_sum[0], r_mq[WIDTH-1:1]};
                    end else begin
                        r_acc <= w_shift;
                    end
                    r_cnt <= r_cnt - CNT_ONE;
                    if (w_last) begin
                        r_result <= w_fin_res;
                        r_status <= w_fin_st;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= FIN;
                    end
                end
                FIN: r_state <= IDLE;
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign result_out = r_result;
    assign status_out = r_status;
    assign busy_out   = r_busy;
    assign done_out   = r_done;

endmodule
